// File: rtl/dff_bank_sched.sv
// Round-robin scheduler/sequencer for a WIDTH-bit bank of clear/preset D flip-flops.
// Latency: a granted op holds gnt for (1 or PULSE)+RECOV+1 cycles, done pulses in the last one.
// Backpressure: requests are level-held; requests seen while busy wait for the next IDLE cycle.
//
// Ports:
//   clk, clr_n          clock (rising edge), asynchronous active-low reset
//   req/op/wdata        per-requester request level, 2-bit opcode, load data
//   gnt/done/busy       one-hot grant, one-cycle completion pulse, sequencer active
//   bank_d/bank_en      load data and load strobe to the bank
//   bank_clr/bank_pr    timed active-high clear / preset pulses to the bank
//   bank_q              bank readback
//   rdata/err           readback captured at completion, sticky mismatch flag
module dff_bank_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 3,
  parameter int PULSE = 2,
  parameter int RECOV = 1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      bank_d,
  output logic                  bank_en,
  output logic                  bank_clr,
  output logic                  bank_pr,
  input  logic [WIDTH-1:0]      bank_q,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err
);

  localparam int PW   = $clog2(NREQ);
  localparam int CMAX = (PULSE > RECOV) ? PULSE : RECOV;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RECOV,
    ST_CHECK
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  bank_d_q, bank_d_d;
  logic              bank_en_q, bank_en_d;
  logic              bank_clr_q, bank_clr_d;
  logic              bank_pr_q, bank_pr_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;

  // Round-robin search: first set req starting one past the last grant.
  logic              arb_found;
  int                arb_idx;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_wdata;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!arb_found && req[(int'(ptr_q) + k) % NREQ]) begin
        arb_found = 1'b1;
        arb_idx   = (int'(ptr_q) + k) % NREQ;
      end
    end
    sel_op    = op[2*arb_idx +: 2];
    sel_wdata = wdata[WIDTH*arb_idx +: WIDTH];
  end

  // Next-state and registered-output logic. Outputs are computed for the
  // state being entered, so every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    bank_d_d   = bank_d_q;
    bank_en_d  = bank_en_q;
    bank_clr_d = bank_clr_q;
    bank_pr_d  = bank_pr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d      = '0;
        bank_d_d   = '0;
        bank_en_d  = 1'b0;
        bank_clr_d = 1'b0;
        bank_pr_d  = 1'b0;
        if (arb_found) begin
          state_d = ST_EXEC;
          ptr_d   = PW'(arb_idx);
          gnt_d   = NREQ'(1) << arb_idx;
          case (sel_op)
            OP_LOAD: begin
              exp_d     = sel_wdata;
              bank_d_d  = sel_wdata;
              bank_en_d = 1'b1;
              cnt_d     = '0;
            end
            OP_CLEAR: begin
              exp_d      = '0;
              bank_clr_d = 1'b1;
              cnt_d      = CW'(PULSE - 1);
            end
            OP_PRESET: begin
              exp_d     = '1;
              bank_pr_d = 1'b1;
              cnt_d     = CW'(PULSE - 1);
            end
            default: begin  // OP_TOGGLE: invert what the bank holds right now
              exp_d     = ~bank_q;
              bank_d_d  = ~bank_q;
              bank_en_d = 1'b1;
              cnt_d     = '0;
            end
          endcase
        end
      end

      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d    = ST_RECOV;
          cnt_d      = CW'(RECOV - 1);
          bank_d_d   = '0;
          bank_en_d  = 1'b0;
          bank_clr_d = 1'b0;
          bank_pr_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RECOV: begin
        if (cnt_q == '0) begin
          // Readback is sampled after the recovery gap so the bank has settled.
          state_d = ST_CHECK;
          done_d  = gnt_q;
          rdata_d = bank_q;
          if (bank_q != exp_q) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin  // ST_CHECK
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      exp_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      bank_d_q   <= '0;
      bank_en_q  <= 1'b0;
      bank_clr_q <= 1'b0;
      bank_pr_q  <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      bank_d_q   <= bank_d_d;
      bank_en_q  <= bank_en_d;
      bank_clr_q <= bank_clr_d;
      bank_pr_q  <= bank_pr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign bank_d   = bank_d_q;
  assign bank_en  = bank_en_q;
  assign bank_clr = bank_clr_q;
  assign bank_pr  = bank_pr_q;
  assign rdata    = rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dff_bank_sched.sv
module tb_dff_bank_sched;

  localparam logic [1:0] LOAD   = 2'b00;
  localparam logic [1:0] CLEAR  = 2'b01;
  localparam logic [1:0] PRESET = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [2:0]  req;
  logic [5:0]  op;
  logic [11:0] wdata;
  logic [2:0]  gnt, done;
  logic        busy, bank_en, bank_clr, bank_pr, err;
  logic [3:0]  bank_d, bank_q, rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dff_bank_sched #(.WIDTH(4), .NREQ(3), .PULSE(2), .RECOV(1)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .op(op), .wdata(wdata),
    .gnt(gnt), .done(done), .busy(busy), .bank_d(bank_d), .bank_en(bank_en),
    .bank_clr(bank_clr), .bank_pr(bank_pr), .bank_q(bank_q), .rdata(rdata), .err(err)
  );

  // Bank model; bank_stuck makes PRESET leave the bank at zero.
  logic bank_stuck = 1'b0;
  logic [3:0] bank_m = 4'h0;
  assign bank_q = bank_m;
  always @(posedge clk) begin
    if (bank_clr)     bank_m <= 4'h0;
    else if (bank_pr) bank_m <= bank_stuck ? 4'h0 : 4'hF;
    else if (bank_en) bank_m <= bank_d;
  end

  // Monitor: grant/done log plus invariant violation counter.
  int cyc = 0;
  int clr_hi = 0, pr_hi = 0, viol = 0;
  logic [2:0] prev_gnt = 3'b000;
  int grant_q[$];
  int gcyc_q[$];
  logic [3:0] rdata_q[$];
  logic [2:0] done_q[$];

  function automatic int oh_idx(input logic [2:0] v);
    int r = 7;
    for (int i = 0; i < 3; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (gnt != 3'b000 && gnt != prev_gnt) begin
      if (prev_gnt != 3'b000) viol++;
      grant_q.push_back(oh_idx(gnt));
      gcyc_q.push_back(cyc);
    end
    if (done != 3'b000) begin
      done_q.push_back(done);
      rdata_q.push_back(rdata);
    end
    if (bank_clr) clr_hi++;
    if (bank_pr)  pr_hi++;
    if ((bank_clr && bank_pr) || (bank_en && (bank_clr || bank_pr))) viol++;
    if (busy && !$onehot(gnt)) viol++;
    prev_gnt = gnt;
  end

  task automatic clear_log();
    grant_q.delete(); gcyc_q.delete(); rdata_q.delete(); done_q.delete();
    clr_hi = 0; pr_hi = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clr_n = 1'b0; req = '0; op = '0; wdata = '0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Drives one request until its done pulse (bounded), then drops it.
  task automatic do_op(input int idx, input logic [1:0] opc, input logic [3:0] dat,
                       output bit ok, output int gcyc, output logic [3:0] rd,
                       output logic [3:0] en_d, output int en_n,
                       output logic [2:0] done_m, output logic err_at);
    ok = 0; gcyc = 0; rd = '0; en_d = '0; en_n = 0; done_m = '0; err_at = 1'b0;
    @(negedge clk);
    op[2*idx +: 2] = opc; wdata[4*idx +: 4] = dat; req[idx] = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (gnt != 3'b000) gcyc++;
      if (bank_en) begin en_n++; en_d = bank_d; end
      if (done != 3'b000) begin
        ok = 1; done_m = done; rd = rdata; err_at = err; req[idx] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr_n = 1'b0; req = '0; op = '0; wdata = '0;
    @(negedge clk);
    n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", gnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if ({bank_en, bank_clr, bank_pr, done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 000000", {bank_en, bank_clr, bank_pr, done}); end
    n_chk++; if ({bank_d, rdata, err} !== 9'b0) begin
      n_fail++; $display("FAIL reset_data got %h want 000", {bank_d, rdata, err}); end
    clr_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || gnt !== 3'b000) begin
      n_fail++; $display("FAIL idle_no_req got busy=%b gnt=%b want 0/000", busy, gnt); end
  endtask

  task automatic test_load();
    bit ok; int gc, en_n; logic [3:0] rd, en_d; logic [2:0] dm; logic ea;
    do_op(0, LOAD, 4'hA, ok, gc, rd, en_d, en_n, dm, ea);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL load_done_timeout got none want done"); end
    n_chk++; if (gc !== 3) begin n_fail++; $display("FAIL load_gnt_cycles got %0d want 3", gc); end
    n_chk++; if (en_n !== 1 || en_d !== 4'hA) begin
      n_fail++; $display("FAIL load_strobe got n=%0d d=%h want 1/A", en_n, en_d); end
    n_chk++; if (dm !== 3'b001 || rd !== 4'hA || ea !== 1'b0) begin
      n_fail++; $display("FAIL load_done got done=%b rdata=%h err=%b want 001/A/0", dm, rd, ea); end
    @(negedge clk);
    n_chk++; if (gnt !== 3'b000 || busy !== 1'b0 || done !== 3'b000) begin
      n_fail++; $display("FAIL load_release got gnt=%b busy=%b done=%b want 000/0/000", gnt, busy, done); end
  endtask

  task automatic test_arbitration();
    int ndone = 0;
    logic [15:0] ord, rds;
    logic [11:0] gaps;
    reset_dut();
    clear_log();
    viol = 0;
    @(negedge clk);
    op = {LOAD, PRESET, CLEAR}; wdata = {4'h5, 4'h0, 4'h0}; req = 3'b111;
    for (int c = 0; c < 80 && ndone < 4; c++) begin
      @(negedge clk);
      if (done != 3'b000) begin ndone++; if (ndone == 4) req = '0; end
    end
    @(negedge clk);
    ord = '0; rds = '0; gaps = '0;
    for (int i = 0; i < grant_q.size() && i < 4; i++) ord = {ord[11:0], 4'(grant_q[i])};
    for (int i = 0; i < rdata_q.size() && i < 4; i++) rds = {rds[11:0], rdata_q[i]};
    for (int i = 1; i < gcyc_q.size() && i < 4; i++) gaps = {gaps[7:0], 4'(gcyc_q[i] - gcyc_q[i-1])};
    n_chk++; if (ndone !== 4) begin n_fail++; $display("FAIL rr_done_count got %0d want 4", ndone); end
    n_chk++; if (ord !== 16'h0120) begin n_fail++; $display("FAIL rr_order got %h want 0120", ord); end
    n_chk++; if (gaps !== 12'h554) begin n_fail++; $display("FAIL rr_grant_spacing got %h want 554", gaps); end
    n_chk++; if (rds !== 16'h0F50) begin n_fail++; $display("FAIL rr_rdata got %h want 0F50", rds); end
    n_chk++; if (clr_hi !== 4 || pr_hi !== 2) begin
      n_fail++; $display("FAIL rr_pulse_len got clr=%0d pr=%0d want 4/2", clr_hi, pr_hi); end
    n_chk++; if (viol !== 0) begin n_fail++; $display("FAIL rr_invariants got %0d violations want 0", viol); end
  endtask

  task automatic test_toggle();
    bit ok; int gc, en_n; logic [3:0] rd, en_d; logic [2:0] dm; logic ea;
    do_op(1, LOAD, 4'h3, ok, gc, rd, en_d, en_n, dm, ea);
    n_chk++; if (!ok || rd !== 4'h3) begin n_fail++; $display("FAIL tog_setup got ok=%0d rdata=%h want 1/3", ok, rd); end
    do_op(1, TOGGLE, 4'h0, ok, gc, rd, en_d, en_n, dm, ea);
    n_chk++; if (en_n !== 1 || en_d !== 4'hC) begin
      n_fail++; $display("FAIL tog_strobe got n=%0d d=%h want 1/C", en_n, en_d); end
    n_chk++; if (!ok || dm !== 3'b010 || rd !== 4'hC) begin
      n_fail++; $display("FAIL tog_done got ok=%0d done=%b rdata=%h want 1/010/C", ok, dm, rd); end
  endtask

  task automatic test_err();
    bit ok; int gc, en_n; logic [3:0] rd, en_d; logic [2:0] dm; logic ea;
    bank_stuck = 1'b1;
    do_op(2, PRESET, 4'h0, ok, gc, rd, en_d, en_n, dm, ea);
    bank_stuck = 1'b0;
    n_chk++; if (!ok || gc !== 4) begin n_fail++; $display("FAIL err_preset_len got ok=%0d gnt=%0d want 1/4", ok, gc); end
    n_chk++; if (rd !== 4'h0 || ea !== 1'b1) begin
      n_fail++; $display("FAIL err_set got rdata=%h err=%b want 0/1", rd, ea); end
    do_op(0, LOAD, 4'h6, ok, gc, rd, en_d, en_n, dm, ea);
    n_chk++; if (!ok || rd !== 4'h6 || ea !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got ok=%0d rdata=%h err=%b want 1/6/1", ok, rd, ea); end
    reset_dut();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    logic [2:0] first_gnt = '0;
    clear_log();
    @(negedge clk);
    op[1:0] = CLEAR; req[0] = 1'b1;
    for (int c = 0; c < 20 && !bank_clr; c++) @(negedge clk);
    @(negedge clk);
    n_chk++; if (bank_clr !== 1'b1) begin n_fail++; $display("FAIL rmid_pulse2 got %b want 1", bank_clr); end
    op[3:2] = LOAD; wdata[7:4] = 4'h9; req[1] = 1'b1;
    #2 clr_n = 1'b0;
    #1;
    n_chk++; if ({gnt, done, busy, bank_en, bank_clr, bank_pr} !== 10'b0) begin
      n_fail++; $display("FAIL rmid_async got %b want 0000000000", {gnt, done, busy, bank_en, bank_clr, bank_pr}); end
    req[0] = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (gnt != 3'b000 && first_gnt == 3'b000) first_gnt = gnt;
      if (done != 3'b000) begin seen = 1; req[1] = 1'b0; end
    end
    @(negedge clk);
    n_chk++; if (first_gnt !== 3'b010) begin n_fail++; $display("FAIL rmid_regrant got %b want 010", first_gnt); end
    n_chk++; if (done_q.size() !== 1 || (done_q.size() > 0 && done_q[0] !== 3'b010)) begin
      n_fail++; $display("FAIL rmid_no_done got %0d dones want 1 (010)", done_q.size()); end
    n_chk++; if (rdata !== 4'h9) begin n_fail++; $display("FAIL rmid_rdata got %h want 9", rdata); end
  endtask

  task automatic test_back_to_back();
    bit got0 = 0, got1 = 0;
    logic [3:0] rd0 = '0;
    clear_log();
    @(negedge clk);
    op[1:0] = LOAD; wdata[3:0] = 4'h7; req[0] = 1'b1;
    for (int c = 0; c < 20 && gnt == 3'b000; c++) @(negedge clk);
    @(negedge clk);
    req[0] = 1'b0; op[1:0] = PRESET; wdata[3:0] = 4'h0;
    op[3:2] = LOAD; wdata[7:4] = 4'h2; req[1] = 1'b1;
    for (int c = 0; c < 40 && !got1; c++) begin
      if (done == 3'b001) begin got0 = 1; rd0 = rdata; end
      if (done == 3'b010) begin got1 = 1; req[1] = 1'b0; end
      if (!got1) @(negedge clk);
    end
    @(negedge clk);
    n_chk++; if (!got0 || rd0 !== 4'h7) begin
      n_fail++; $display("FAIL b2b_done0 got seen=%0d rdata=%h want 1/7", got0, rd0); end
    n_chk++; if (!got1) begin n_fail++; $display("FAIL b2b_done1_timeout got none want done"); end
    n_chk++; if (grant_q.size() !== 2 || gcyc_q.size() !== 2 || grant_q[0] !== 0 || grant_q[1] !== 1) begin
      n_fail++; $display("FAIL b2b_order got %0d grants want 0 then 1", grant_q.size()); end
    else begin
      n_chk++; if (gcyc_q[1] - gcyc_q[0] !== 4) begin
        n_fail++; $display("FAIL b2b_gap got %0d want 4", gcyc_q[1] - gcyc_q[0]); end
    end
    n_chk++; if (viol !== 0) begin n_fail++; $display("FAIL invariants got %0d violations want 0", viol); end
  endtask

  initial begin
    clr_n = 1'b0; req = '0; op = '0; wdata = '0;
    test_reset();
    test_load();
    test_arbitration();
    test_toggle();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
